taus_urng: RTL and testbench

//  32-bit uniform random number generator (taus88: three combined Tausworthe LFSRs) feeding the

---
 rtl/taus_urng.sv | 84 ++++++++
 tb/tb_taus_urng.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/taus_urng.sv
// taus_urng: taus88 uniform random word generator with reseeding and warm-up
module taus_urng #(
  parameter int          WARMUP_CYCLES = 16,
  parameter logic [31:0] DEFAULT_S0    = 32'h1234_5678,
  parameter logic [31:0] DEFAULT_S1    = 32'h9ABC_DEF0,
  parameter logic [31:0] DEFAULT_S2    = 32'h0F1E_2D3C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        seed_we,
  input  logic [31:0] seed_data,
  output logic [31:0] u,
  output logic        u_valid,
  output logic        busy
);
  localparam int CW = $clog2(WARMUP_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WARMUP_CYCLES - 1);
  typedef enum logic [1:0] {WARMUP, RUN, LOAD1, LOAD2} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] s0, s1, s2, n0, n1, n2, word;
  // one taus88 step of all three component generators
  always_comb begin
    n0   = ((s0 & 32'hFFFF_FFFE) << 12) ^ (((s0 << 13) ^ s0) >> 19);
    n1   = ((s1 & 32'hFFFF_FFF8) << 4) ^ (((s1 << 2) ^ s1) >> 25);
    n2   = ((s2 & 32'hFFFF_FFF0) << 17) ^ (((s2 << 3) ^ s2) >> 11);
    word = n0 ^ n1 ^ n2;
  end
  // seed loading, warm-up stepping and output generation; seed writes beat en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0      <= DEFAULT_S0 | 32'd2;
      s1      <= DEFAULT_S1 | 32'd8;
      s2      <= DEFAULT_S2 | 32'd16;
      state   <= WARMUP;
      cnt     <= '0;
      u       <= '0;
      u_valid <= 1'b0;
      busy    <= 1'b1;
    end else begin
      u_valid <= 1'b0;
      case (state)
        WARMUP:
          if (seed_we) begin
            s0    <= seed_data | 32'd2;
            state <= LOAD1;
          end else begin
            s0  <= n0;
            s1  <= n1;
            s2  <= n2;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= RUN;
              busy  <= 1'b0;
            end
          end
        RUN:
          if (seed_we) begin
            s0    <= seed_data | 32'd2;
            state <= LOAD1;
            busy  <= 1'b1;
          end else if (en) begin
            s0      <= n0;
            s1      <= n1;
            s2      <= n2;
            u       <= word;
            u_valid <= 1'b1;
          end
        LOAD1:
          if (seed_we) begin
            s1    <= seed_data | 32'd8;
            state <= LOAD2;
          end
        LOAD2:
          if (seed_we) begin
            s2    <= seed_data | 32'd16;
            state <= WARMUP;
            cnt   <= '0;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_taus_urng.sv
// tb_taus_urng: directed self-checking bench for taus_urng against a taus88 reference
module tb_taus_urng;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic seed_we = 1'b0;
  logic [31:0] seed_data = '0;
  logic [31:0] u;
  logic u_valid, busy;
  int errors = 0;
  int checks = 0;
  logic [31:0] m0, m1, m2;

  taus_urng dut (
    .clk(clk), .rst(rst), .en(en), .seed_we(seed_we), .seed_data(seed_data),
    .u(u), .u_valid(u_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference taus88 step as in the published C code
  task automatic model_step(output logic [31:0] w);
    logic [31:0] b;
    b  = ((m0 << 13) ^ m0) >> 19;
    m0 = ((m0 & 32'hFFFF_FFFE) << 12) ^ b;
    b  = ((m1 << 2) ^ m1) >> 25;
    m1 = ((m1 & 32'hFFFF_FFF8) << 4) ^ b;
    b  = ((m2 << 3) ^ m2) >> 11;
    m2 = ((m2 & 32'hFFFF_FFF0) << 17) ^ b;
    w  = m0 ^ m1 ^ m2;
  endtask

  task automatic model_seed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] w;
    m0 = a | 32'd2;
    m1 = b | 32'd8;
    m2 = c | 32'd16;
    for (int i = 0; i < 16; i++) model_step(w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (u !== 32'd0 || u_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: u=%h u_valid=%b busy=%b required u=0 u_valid=0 busy=1", u, u_valid, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (busy !== (i < 16) || u_valid !== 1'b0 || u !== 32'd0) begin
        errors++;
        $display("FAIL warmup_busy cycle %0d: busy=%b u_valid=%b u=%h required busy=%b u_valid=0 u=0",
                 i, busy, u_valid, u, i < 16);
      end
    end
    model_seed(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C);
  endtask

  task automatic test_stream();
    logic [31:0] w;
    en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      model_step(w);
      checks++;
      if (u_valid !== 1'b1 || u !== w) begin
        errors++;
        $display("FAIL stream word %0d: u=%h u_valid=%b required u=%h u_valid=1", i, u, u_valid, w);
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (u_valid !== 1'b0 || u !== w) begin
      errors++;
      $display("FAIL stream_stop: u=%h u_valid=%b required u=%h u_valid=0", u, u_valid, w);
    end
  endtask

  task automatic test_reseed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
    logic [31:0] w;
    seed_we = 1'b1;
    seed_data = a;
    tick();
    seed_data = b;
    tick();
    seed_data = c;
    tick();
    seed_we = 1'b0;
    checks++;
    if (dut.s0 !== ea || dut.s1 !== eb || dut.s2 !== ec || busy !== 1'b1) begin
      errors++;
      $display("FAIL seed_sanitise: s0=%h s1=%h s2=%h busy=%b required s0=%h s1=%h s2=%h busy=1",
               dut.s0, dut.s1, dut.s2, busy, ea, eb, ec);
    end
    repeat (15) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reseed_warmup_15: busy=%b required 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reseed_warmup_16: busy=%b required 0", busy);
    end
    model_seed(a, b, c);
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      model_step(w);
      checks++;
      if (u_valid !== 1'b1 || u !== w) begin
        errors++;
        $display("FAIL reseed_stream word %0d: u=%h u_valid=%b required u=%h", i, u, u_valid, w);
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_en_gap();
    logic [31:0] w;
    logic [31:0] held;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    held = u;
    for (int i = 0; i < 4; i++) begin
      en = pat[i];
      tick();
      if (pat[i]) begin
        model_step(w);
        held = w;
      end
      checks++;
      if (u_valid !== pat[i] || u !== held) begin
        errors++;
        $display("FAIL en_gap step %0d: u=%h u_valid=%b required u=%h u_valid=%b", i, u, u_valid, held, pat[i]);
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (dut.s0 !== m0 || dut.s1 !== m1 || dut.s2 !== m2 || u_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_gap_steps: s0=%h u_valid=%b required s0=%h u_valid=0", dut.s0, u_valid, m0);
    end
  endtask

  task automatic test_seed_en_collide();
    logic [31:0] w;
    seed_we = 1'b1;
    en = 1'b1;
    seed_data = 32'hDEAD_BEEF;
    tick();
    en = 1'b0;
    checks++;
    if (u_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL seed_en_collide: u_valid=%b busy=%b required u_valid=0 busy=1", u_valid, busy);
    end
    seed_data = 32'h0000_0005;
    tick();
    seed_data = 32'hCAFE_F00D;
    tick();
    seed_we = 1'b0;
    repeat (15) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL collide_warmup_15: busy=%b required 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL collide_warmup_16: busy=%b required 0", busy);
    end
    model_seed(32'hDEAD_BEEF, 32'h0000_0005, 32'hCAFE_F00D);
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      model_step(w);
      checks++;
      if (u_valid !== 1'b1 || u !== w) begin
        errors++;
        $display("FAIL collide_stream word %0d: u=%h required %h", i, u, w);
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_reset_midload();
    logic [31:0] w;
    seed_we = 1'b1;
    seed_data = 32'h0BAD_0BAD;
    tick();
    seed_we = 1'b0;
    rst = 1'b1;
    #3;
    checks++;
    if (u !== 32'd0 || u_valid !== 1'b0 || busy !== 1'b1 || dut.s0 !== 32'h1234_567A) begin
      errors++;
      $display("FAIL midload_reset: u=%h u_valid=%b busy=%b s0=%h required u=0 u_valid=0 busy=1 s0=1234567a",
               u, u_valid, busy, dut.s0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (16) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midload_warmup: busy=%b required 0", busy);
    end
    model_seed(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C);
    en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      model_step(w);
      checks++;
      if (u_valid !== 1'b1 || u !== w) begin
        errors++;
        $display("FAIL midload_stream word %0d: u=%h required %h", i, u, w);
      end
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reseed(32'd0, 32'd1, 32'd7, 32'd2, 32'd9, 32'd23);
    test_reseed(32'd1, 32'd7, 32'd15, 32'd3, 32'd15, 32'd31);
    test_en_gap();
    test_seed_en_collide();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
